// File: rtl/decode_stage.sv
// Decode stage: FD pipeline register, 32-entry register file with write-back bypass,
// field/immediate extraction, branch target, load-use hazard detection and perf counters.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [31:0]      f_instr,
  input  logic [XLEN-1:0]  f_pc,
  input  logic             x_redirect,
  input  logic             dx_mem_read,
  input  logic [4:0]       dx_rt_addr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             cnt_clr,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_jmp,
  output logic [4:0]       rs_a,
  output logic [4:0]       rt_a,
  output logic [4:0]       rd_a,
  output logic [XLEN-1:0]  rs_d,
  output logic [XLEN-1:0]  rt_d,
  output logic [XLEN-1:0]  imm,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // FD pipeline register
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Architectural register file
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  // Performance counters
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic haz;
  logic wb_active;

  // ---------------------------------------------------------------------------
  // Field extraction. The FD instruction is forced to zero whenever the slot is
  // empty, so every derived field reads zero for an invalid FD entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_o = instr_q;
    pc_o    = pc_q;
    rs_a    = instr_q[25:21];
    rt_a    = instr_q[20:16];
    rd_a    = instr_q[15:11];
    imm     = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    pc_jmp  = pc_q + XLEN'(4) + (imm << 2);
  end

  // ---------------------------------------------------------------------------
  // Register reads: combinational, r0 hard-wired to zero, same-cycle bypass of
  // the write-back port so a value written this cycle is visible immediately.
  // ---------------------------------------------------------------------------
  assign wb_active = wb_en && (wb_addr != 5'd0);

  always_comb begin
    rs_d = '0;
    rt_d = '0;
    if (rs_a != 5'd0) begin
      if (wb_active && (wb_addr == rs_a)) begin
        rs_d = wb_data;
      end else begin
        rs_d = rf_q[rs_a];
      end
    end
    if (rt_a != 5'd0) begin
      if (wb_active && (wb_addr == rt_a)) begin
        rt_d = wb_data;
      end else begin
        rt_d = rf_q[rt_a];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard / control handshake with fetch and DX:
  //   stall=1  -> fetch and the FD register hold their contents this edge.
  //   bubble=1 -> DX loads a NOP instead of the FD instruction this edge.
  // A load in DX whose destination feeds the FD instruction costs one stall
  // cycle; a redirect flushes FD instead, so it kills the stall but keeps the
  // bubble (the wrong-path FD instruction must never reach DX).
  // ---------------------------------------------------------------------------
  always_comb begin
    haz = valid_q && dx_mem_read && (dx_rt_addr != 5'd0) &&
          ((dx_rt_addr == rs_a) || (dx_rt_addr == rt_a));
    stall  = haz && !x_redirect;
    bubble = haz || x_redirect;
  end

  // FD next state: flush beats stall beats normal load.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (x_redirect) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
    end else if (!stall) begin
      valid_d = f_valid;
      instr_d = f_valid ? f_instr : 32'd0;
      pc_d    = f_pc;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_active) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  // Counters saturate at all-ones; a clear in the same cycle wins.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (cnt_clr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (x_redirect && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand-computed vector table, directed corner sequences,
// and randomized traffic checked against a high-level reference model.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             f_valid;
  logic [31:0]      f_instr;
  logic [XLEN-1:0]  f_pc;
  logic             x_redirect;
  logic             dx_mem_read;
  logic [4:0]       dx_rt_addr;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             cnt_clr;
  logic [31:0]      instr_o;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_jmp;
  logic [4:0]       rs_a, rt_a, rd_a;
  logic [XLEN-1:0]  rs_d, rt_d, imm;
  logic             stall, bubble;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(XLEN), .NREGS(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .x_redirect(x_redirect), .dx_mem_read(dx_mem_read), .dx_rt_addr(dx_rt_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .cnt_clr(cnt_clr),
    .instr_o(instr_o), .pc_o(pc_o), .pc_jmp(pc_jmp), .rs_a(rs_a), .rt_a(rt_a),
    .rd_a(rd_a), .rs_d(rs_d), .rt_d(rt_d), .imm(imm), .stall(stall),
    .bubble(bubble), .stall_count(stall_count), .flush_count(flush_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  int          m_sc, m_fc;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_sc = 0;
    m_fc = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_haz();
    logic [4:0] s, t;
    s = m_instr[25:21];
    t = m_instr[20:16];
    return m_valid && dx_mem_read && dx_rt_addr != 5'd0 &&
           (dx_rt_addr == s || dx_rt_addr == t);
  endfunction

  task automatic model_update();
    logic st;
    st = m_haz() && !x_redirect;
    if (cnt_clr) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (st && m_sc < CNT_SAT) m_sc++;
      if (x_redirect && m_fc < CNT_SAT) m_fc++;
    end
    if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    if (x_redirect) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_pc    = '0;
    end else if (!st) begin
      m_valid = f_valid;
      m_instr = f_valid ? f_instr : 32'd0;
      m_pc    = f_pc;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_check();
    int signed simm;
    logic [31:0] e_jmp;
    logic h;
    simm  = $signed(m_instr[15:0]);
    e_jmp = m_pc + 32'd4 + 32'(simm * 4);
    h     = m_haz();
    chk("m_instr", instr_o, m_instr);
    chk("m_pc", pc_o, m_pc);
    chk("m_pc_jmp", pc_jmp, e_jmp);
    chk("m_rs_a", 32'(rs_a), 32'(m_instr[25:21]));
    chk("m_rt_a", 32'(rt_a), 32'(m_instr[20:16]));
    chk("m_rd_a", 32'(rd_a), 32'(m_instr[15:11]));
    chk("m_imm", imm, 32'(simm));
    chk("m_rs_d", rs_d, m_read(m_instr[25:21]));
    chk("m_rt_d", rt_d, m_read(m_instr[20:16]));
    chk("m_stall", 32'(stall), 32'(h && !x_redirect));
    chk("m_bubble", 32'(bubble), 32'(h || x_redirect));
    chk("m_stall_count", 32'(stall_count), 32'(m_sc));
    chk("m_flush_count", 32'(flush_count), 32'(m_fc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    f_valid = 0; f_instr = '0; f_pc = '0; x_redirect = 0; dx_mem_read = 0;
    dx_rt_addr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; cnt_clr = 0;
  endtask

  // Called at a negedge with inputs already driven: check, clock, return at next negedge.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] fi;
    logic [31:0] fpc;
    logic        xr;
    logic        dxm;
    logic [4:0]  dxrt;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        clr;
    logic [31:0] e_instr;
    logic        e_stall;
    logic        e_bubble;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [3:0]  e_sc;
    logic [3:0]  e_fc;
  } vec_t;

  localparam logic [31:0] I1 = 32'h00A3_3020; // rs=5 rt=3 rd=6
  localparam logic [31:0] I2 = 32'h0005_3820; // rs=0 rt=5 rd=7
  localparam logic [31:0] I3 = 32'h0060_0020; // rs=3 rt=0

  vec_t vecs[11];

  initial begin
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bubble", 32'(bubble), 32'd0);
    chk("rst_scnt", 32'(stall_count), 32'd0);
    @(negedge clk);

    //            fv fi  fpc       xr dxm dxrt wbe wba wbd            clr e_instr st bu e_rs          e_rt          sc fc
    vecs[0]  = '{1, I1, 32'h100, 0, 0, 5'd0, 0, 5'd0, 32'h0,        0, 32'h0, 0, 0, 32'h0,        32'h0,        0, 0};
    vecs[1]  = '{1, I1, 32'h104, 0, 0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, I1,    0, 0, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{1, I2, 32'h108, 0, 0, 5'd0, 1, 5'd0, 32'h1234,     0, I1,    0, 0, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[3]  = '{1, I3, 32'h10C, 0, 0, 5'd0, 0, 5'd0, 32'h0,        0, I2,    0, 0, 32'h0,        32'hDEADBEEF, 0, 0};
    vecs[4]  = '{1, I1, 32'h110, 0, 1, 5'd3, 0, 5'd0, 32'h0,        0, I3,    1, 1, 32'h0,        32'h0,        0, 0};
    vecs[5]  = '{1, I1, 32'h110, 0, 0, 5'd0, 0, 5'd0, 32'h0,        0, I3,    0, 0, 32'h0,        32'h0,        1, 0};
    vecs[6]  = '{1, I3, 32'h114, 0, 1, 5'd0, 0, 5'd0, 32'h0,        0, I1,    0, 0, 32'hDEADBEEF, 32'h0,        1, 0};
    vecs[7]  = '{1, I1, 32'h118, 1, 1, 5'd3, 0, 5'd0, 32'h0,        0, I3,    0, 1, 32'h0,        32'h0,        1, 0};
    vecs[8]  = '{0, 32'hFFFFFFFF, 32'h11C, 0, 0, 5'd0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1};
    vecs[9]  = '{0, 32'h0, 32'h120, 0, 0, 5'd0, 0, 5'd0, 32'h0,     1, 32'h0, 0, 0, 32'h0,        32'h0,        1, 1};
    vecs[10] = '{0, 32'h0, 32'h124, 0, 0, 5'd0, 0, 5'd0, 32'h0,     0, 32'h0, 0, 0, 32'h0,        32'h0,        0, 0};

    for (int i = 0; i < 11; i++) begin
      f_valid = vecs[i].fv;   f_instr = vecs[i].fi;    f_pc = vecs[i].fpc;
      x_redirect = vecs[i].xr; dx_mem_read = vecs[i].dxm; dx_rt_addr = vecs[i].dxrt;
      wb_en = vecs[i].wbe;    wb_addr = vecs[i].wba;   wb_data = vecs[i].wbd;
      cnt_clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].e_instr);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_bubble", i), 32'(bubble), 32'(vecs[i].e_bubble));
      chk($sformatf("vec%0d_rs_d", i), rs_d, vecs[i].e_rs);
      chk($sformatf("vec%0d_rt_d", i), rt_d, vecs[i].e_rt);
      chk($sformatf("vec%0d_scnt", i), 32'(stall_count), 32'(vecs[i].e_sc));
      chk($sformatf("vec%0d_fcnt", i), 32'(flush_count), 32'(vecs[i].e_fc));
      tick();
    end

    // Branch target with negative immediate, then PC wrap-around.
    drive_idle();
    f_valid = 1; f_instr = 32'h1000_FFFF; f_pc = 32'h0000_0100;
    tick();
    f_instr = 32'h1000_0000; f_pc = 32'hFFFF_FFFC;
    #1;
    chk("br_imm", imm, 32'hFFFF_FFFF);
    chk("br_jmp", pc_jmp, 32'h0000_0100);
    tick();
    f_valid = 0;
    #1;
    chk("br_wrap", pc_jmp, 32'h0000_0000);
    tick();

    // Counter saturation under a held load-use stall, then clear while stalled.
    f_valid = 1; f_instr = I3; f_pc = 32'h200;
    tick();
    dx_mem_read = 1; dx_rt_addr = 5'd3;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    chk("sat_scnt", 32'(stall_count), 32'hF);
    chk("sat_instr_held", instr_o, I3);
    cnt_clr = 1;
    #1;
    chk("clr_stall_on", 32'(stall), 32'd1);
    tick();
    cnt_clr = 0; dx_mem_read = 0;
    #1;
    chk("clr_scnt", 32'(stall_count), 32'd0);
    tick();

    // Asynchronous reset mid-cycle while FD holds a load.
    f_valid = 1; f_instr = 32'h8C22_0004; f_pc = 32'h300;
    wb_en = 1; wb_addr = 5'd2; wb_data = 32'hCAFE_F00D;
    tick();
    drive_idle();
    #2;
    chk("pre_rst_instr", instr_o, 32'h8C22_0004);
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_imm", imm, 32'd0);
    chk("arst_jmp", pc_jmp, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      f_valid = 1; f_instr = {6'd0, 5'(r), 5'(r), 16'd0}; f_pc = 32'(r * 4);
      tick();
      chk($sformatf("arst_r%0d", r), rs_d, 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      f_valid = ($urandom_range(0, 3) != 0);
      f_instr = $urandom;
      f_instr[25:21] = 5'($urandom_range(0, 7));
      f_instr[20:16] = 5'($urandom_range(0, 7));
      f_pc = $urandom;
      x_redirect = ($urandom_range(0, 15) == 0);
      dx_mem_read = ($urandom_range(0, 2) == 0);
      dx_rt_addr = 5'($urandom_range(0, 7));
      wb_en = ($urandom_range(0, 1) == 1);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      cnt_clr = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
